// File: rtl/riscv_pkg.sv
// Shared RISC-V encoder types: immediate formats and datapath widths.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int FMT_W = 3;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [FMT_W-1:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

endpackage

// File: rtl/imm_packer.sv
// Combinational immediate packer and range check.
module imm_packer
    import riscv_pkg::*;
(
    input  logic [FMT_W-1:0] fmt,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  base,
    output logic [XLEN-1:0]  instr,
    output logic             err
);

    logic i_ok;
    logic b_ok;
    logic u_ok;
    logic j_ok;

    // Sign-extension checks: upper bits must all be copies of the field MSB.
    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign u_ok = ~(|imm[11:0]);
    assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    always_comb begin
        instr = base;
        err   = 1'b0;
        case (fmt)
            FMT_I: begin
                instr[31:20] = imm[11:0];
                err          = ~i_ok;
            end
            FMT_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err          = ~i_ok;
            end
            FMT_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                err          = ~b_ok;
            end
            FMT_U: begin
                instr[31:12] = imm[31:12];
                err          = ~u_ok;
            end
            FMT_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                err          = ~j_ok;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder pipeline with valid/ready handshakes
// and a saturating error counter.
module imm_encoder
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FMT_W-1:0] in_fmt,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    logic            s1_valid;
    logic [XLEN-1:0] s1_instr;
    logic            s1_err;
    logic [XLEN-1:0] pk_instr;
    logic            pk_err;
    logic            en1;
    logic            en2;

    imm_packer u_packer (
        .fmt   (in_fmt),
        .imm   (in_imm),
        .base  (in_base),
        .instr (pk_instr),
        .err   (pk_err)
    );

    assign en2      = ~out_valid | out_ready;
    assign en1      = ~s1_valid | en2;
    assign in_ready = en1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_err   <= 1'b0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_instr <= pk_instr;
                s1_err   <= pk_err;
            end
        end
    end

    // out_valid doubles as s2_valid; data only moves when a beat moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_instr;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err
                     && err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed, table-driven bench for imm_encoder.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_one(input vec_t v, input int n);
        @(negedge clk);
        in_valid = 1'b1;
        in_fmt   = v.fmt;
        in_imm   = v.imm;
        in_base  = v.base;
        chk($sformatf("v%0d in_ready", n), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d latency1", n), 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d out_instr", n), out_instr, v.instr);
        chk($sformatf("v%0d out_err", n), 32'(out_err), 32'(v.err));
        if (v.err) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d err_count", n), 32'(err_count), 32'(exp_cnt));
    endtask

    logic [31:0] bp_exp[3];
    int idx;
    int got;
    logic acc;
    logic hs;
    logic bad;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        vecs[1]  = '{3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
        vecs[2]  = '{3'd2, 32'hFFFFFFFE, 32'h00000063, 32'hFE000FE3, 1'b0};
        vecs[3]  = '{3'd3, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        vecs[4]  = '{3'd3, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1};
        vecs[5]  = '{3'd1, 32'h000007FF, 32'h00000023, 32'h7E000FA3, 1'b0};
        vecs[6]  = '{3'd4, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0};
        vecs[7]  = '{3'd4, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0};
        vecs[8]  = '{3'd4, 32'h00000003, 32'h0000006F, 32'h0020006F, 1'b1};
        vecs[9]  = '{3'd2, 32'h00001000, 32'h00000063, 32'h80000063, 1'b1};
        vecs[10] = '{3'd5, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        vecs[11] = '{3'd0, 32'hFFFFF7FF, 32'h00000013, 32'h7FF00013, 1'b1};
        vecs[12] = '{3'd7, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1};
        vecs[13] = '{3'd0, 32'h00000001, 32'hFFFFFFFF, 32'h001FFFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_imm    = '0;
        in_base   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) send_one(vecs[i], i);

        // Backpressure: 3 beats offered while the consumer stalls.
        for (int i = 0; i < 3; i++)
            bp_exp[i] = (32'(i + 1) << 20) | 32'h13;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (idx < 3);
            in_fmt   = 3'd0;
            in_imm   = 32'(idx + 1);
            in_base  = 32'h13;
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        chk("bp accepted", 32'(idx), 32'd2);
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp hold instr", out_instr, bp_exp[0]);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = (idx < 3);
            in_imm   = 32'(idx + 1);
            acc      = in_valid && in_ready;
            hs       = out_valid && out_ready;
            if (hs) chk($sformatf("bp order%0d", got), out_instr, bp_exp[got]);
            @(posedge clk);
            if (acc) idx++;
            if (hs) got++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp delivered", 32'(got), 32'd3);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_fmt   = 3'd6;
            in_base  = 32'hCAFEF00D;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        chk("pre-rst in_ready", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async err_count", 32'(err_count), 32'd0);
        chk("async out_instr", out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no stale beat", 32'(bad), 32'd0);

        // Saturation: stream illegal-format beats back to back.
        @(negedge clk);
        in_valid = 1'b1;
        in_fmt   = 3'd5;
        in_base  = 32'h0;
        for (int c = 0; c < 65540; c++) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sat out_err", 32'(out_err), 32'd1);
        repeat (4) @(negedge clk);
        chk("sat err_count", 32'(err_count), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
